// File: rtl/fir_decim_requant.sv
// fir_decim_requant
// Decimating requantiser placed after the symmetric odd FIR. It keeps one
// sample out of every DECIM valid inputs (the one at index PHASE), then rounds
// it half-up, shifts it right arithmetically by SHIFT and saturates it to
// OUT_WIDTH bits. Results go into a 2-entry FIFO with a valid/ready handshake
// toward the consumer.
// The FIR upstream cannot be stalled. When a result arrives at a full FIFO
// that is not being popped, the result is dropped and the sticky overrun flag
// is set.
// Optional build macro FIR_DECIM_REQUANT_SAT_CNT_EN adds a 16-bit saturating
// counter, sat_cnt, of clipped stage-1 samples. The counter is cleared by
// clr_overrun.
// The reset, arst_n, is synchronous and active low.

module fir_decim_requant #(
  parameter int IN_WIDTH  = 25,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 8,
  parameter int DECIM     = 4,
  parameter int PHASE     = 0
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic signed [IN_WIDTH-1:0]  data_in,
  input  logic                        valid_in,
  output logic signed [OUT_WIDTH-1:0] data_out,
  output logic                        valid_out,
  input  logic                        ready_in,
  output logic                        sat_out,
  output logic                        overrun,
`ifdef FIR_DECIM_REQUANT_SAT_CNT_EN
  output logic [15:0]                 sat_cnt,
`endif
  input  logic                        clr_overrun
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  // Phase counter width (at least one bit so DECIM = 1 still elaborates)
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  // One guard bit above the input so the rounding add cannot wrap
  localparam int RW = IN_WIDTH + 1;

  localparam logic [PW-1:0] PHASE_L = PW'(PHASE);
  localparam logic [PW-1:0] LAST_L  = PW'(DECIM - 1);

  // Half an LSB of the shifted result; zero when no shift is applied
  localparam logic signed [RW-1:0] RND =
    (SHIFT > 0) ? RW'(longint'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

  // Saturation limits at the wide width (for compare) and at output width
  localparam logic signed [RW-1:0] SAT_MAX = RW'((longint'(1) << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;

  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Phase selection
  // ---------------------------------------------------------------------------
  logic [PW-1:0] r_phase;
  logic          w_keep;

  // Count valid input samples modulo DECIM; idle cycles do not advance
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_phase <= '0;
    end else if (valid_in) begin
      r_phase <= (r_phase == LAST_L) ? '0 : r_phase + PW'(1);
    end
  end

  assign w_keep = valid_in && (r_phase == PHASE_L);

  // ---------------------------------------------------------------------------
  // Stage 1: round, shift, saturate
  // ---------------------------------------------------------------------------
  logic signed [RW-1:0]        w_ext;
  logic signed [RW-1:0]        w_rnd;
  logic signed [RW-1:0]        w_q;
  logic signed [OUT_WIDTH-1:0] w_req_data;
  logic                        w_req_sat;

  assign w_ext = {data_in[IN_WIDTH-1], data_in};
  assign w_rnd = w_ext + RND;
  assign w_q   = w_rnd >>> SHIFT;

  // Clip the shifted value into the signed OUT_WIDTH range and flag clipping
  always_comb begin
    w_req_data = w_q[OUT_WIDTH-1:0];
    w_req_sat  = 1'b0;
    if (w_q > SAT_MAX) begin
      w_req_data = OUT_MAX;
      w_req_sat  = 1'b1;
    end else if (w_q < SAT_MIN) begin
      w_req_data = OUT_MIN;
      w_req_sat  = 1'b1;
    end
  end

  logic                        r_s1_valid;
  logic signed [OUT_WIDTH-1:0] r_s1_data;
  logic                        r_s1_sat;

  // Register the requantised kept sample together with its clip flag
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_sat   <= 1'b0;
    end else begin
      r_s1_valid <= w_keep;
      if (w_keep) begin
        r_s1_data <= w_req_data;
        r_s1_sat  <= w_req_sat;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: 2-entry FIFO, head register drives the outputs
  // ---------------------------------------------------------------------------
  logic [1:0]                  r_count;
  logic signed [OUT_WIDTH-1:0] r_head_data;
  logic                        r_head_sat;
  logic signed [OUT_WIDTH-1:0] r_tail_data;
  logic                        r_tail_sat;
  logic                        w_pop;
  logic                        w_push;
  logic                        w_drop;

  assign w_pop  = (r_count != 2'd0) && ready_in;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_push = r_s1_valid && ((r_count != 2'd2) || w_pop);
  assign w_drop = r_s1_valid && (r_count == 2'd2) && !w_pop;

  // Update the head/tail entries and the occupancy count
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_count     <= 2'd0;
      r_head_data <= '0;
      r_head_sat  <= 1'b0;
      r_tail_data <= '0;
      r_tail_sat  <= 1'b0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_push) begin
            r_head_data <= r_s1_data;
            r_head_sat  <= r_s1_sat;
            r_count     <= 2'd1;
          end
        end
        2'd1: begin
          case ({w_push, w_pop})
            2'b11: begin
              // Head leaves, new sample becomes the head directly
              r_head_data <= r_s1_data;
              r_head_sat  <= r_s1_sat;
            end
            2'b01: begin
              // Head register keeps its last value while empty
              r_count <= 2'd0;
            end
            2'b10: begin
              r_tail_data <= r_s1_data;
              r_tail_sat  <= r_s1_sat;
              r_count     <= 2'd2;
            end
            default: begin
            end
          endcase
        end
        2'd2: begin
          if (w_pop) begin
            r_head_data <= r_tail_data;
            r_head_sat  <= r_tail_sat;
            if (w_push) begin
              r_tail_data <= r_s1_data;
              r_tail_sat  <= r_s1_sat;
            end else begin
              r_count <= 2'd1;
            end
          end
        end
        default: begin
          r_count <= 2'd0;
        end
      endcase
    end
  end

  assign valid_out = (r_count != 2'd0);
  assign data_out  = r_head_data;
  assign sat_out   = r_head_sat;

  // ---------------------------------------------------------------------------
  // Sticky overrun flag
  // ---------------------------------------------------------------------------
  logic r_overrun;

  // A drop takes priority over a clear arriving in the same cycle
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  assign overrun = r_overrun;

`ifdef FIR_DECIM_REQUANT_SAT_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturation event counter (counts clipped stage-1 samples, even dropped ones)
  // ---------------------------------------------------------------------------
  logic [15:0] r_sat_cnt;

  // Count clipped samples leaving stage 1, holding at all-ones
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_sat_cnt <= '0;
    end else if (clr_overrun) begin
      r_sat_cnt <= '0;
    end else if (r_s1_valid && r_s1_sat && (r_sat_cnt != 16'hFFFF)) begin
      r_sat_cnt <= r_sat_cnt + 16'd1;
    end
  end

  assign sat_cnt = r_sat_cnt;
`endif

endmodule

// File: tb/tb_fir_decim_requant.sv
// Testbench for fir_decim_requant.
// Three instances share one set of input drives:
//   a: DECIM=4, SHIFT=8
//   b: DECIM=1, SHIFT=8
//   c: DECIM=1, SHIFT=0
// Each directed section resets all three instances and then watches one of
// them through a monitor mux.
// Each kept sample's expected {value, sat} is pushed to a queue when it is
// driven. The entry is popped and compared when the selected instance hands
// data over (valid_out && ready_in).

module tb_fir_decim_requant;
  localparam int IW = 25;
  localparam int OW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 arst_n = 1'b0;
  logic                 valid_in = 1'b0;
  logic                 ready_in = 1'b0;
  logic                 clr_overrun = 1'b0;
  logic signed [IW-1:0] data_in = '0;

  logic signed [OW-1:0] a_data, b_data, c_data;
  logic a_valid, b_valid, c_valid;
  logic a_sat, b_sat, c_sat;
  logic a_ovr, b_ovr, c_ovr;
`ifdef FIR_DECIM_REQUANT_SAT_CNT_EN
  logic [15:0] a_cnt, b_cnt, c_cnt;
`endif

  fir_decim_requant #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT(8), .DECIM(4), .PHASE(0)) u_dut_a (
    .clk(clk), .arst_n(arst_n), .data_in(data_in), .valid_in(valid_in),
    .data_out(a_data), .valid_out(a_valid), .ready_in(ready_in),
    .sat_out(a_sat), .overrun(a_ovr),
`ifdef FIR_DECIM_REQUANT_SAT_CNT_EN
    .sat_cnt(a_cnt),
`endif
    .clr_overrun(clr_overrun)
  );

  fir_decim_requant #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT(8), .DECIM(1), .PHASE(0)) u_dut_b (
    .clk(clk), .arst_n(arst_n), .data_in(data_in), .valid_in(valid_in),
    .data_out(b_data), .valid_out(b_valid), .ready_in(ready_in),
    .sat_out(b_sat), .overrun(b_ovr),
`ifdef FIR_DECIM_REQUANT_SAT_CNT_EN
    .sat_cnt(b_cnt),
`endif
    .clr_overrun(clr_overrun)
  );

  fir_decim_requant #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT(0), .DECIM(1), .PHASE(0)) u_dut_c (
    .clk(clk), .arst_n(arst_n), .data_in(data_in), .valid_in(valid_in),
    .data_out(c_data), .valid_out(c_valid), .ready_in(ready_in),
    .sat_out(c_sat), .overrun(c_ovr),
`ifdef FIR_DECIM_REQUANT_SAT_CNT_EN
    .sat_cnt(c_cnt),
`endif
    .clr_overrun(clr_overrun)
  );

  // Monitor mux: which instance the current section observes
  int sel = 0;
  logic signed [OW-1:0] m_data;
  logic m_valid, m_sat, m_ovr;

  always_comb begin
    case (sel)
      0: begin
        m_data = a_data; m_valid = a_valid; m_sat = a_sat; m_ovr = a_ovr;
      end
      1: begin
        m_data = b_data; m_valid = b_valid; m_sat = b_sat; m_ovr = b_ovr;
      end
      default: begin
        m_data = c_data; m_valid = c_valid; m_sat = c_sat; m_ovr = c_ovr;
      end
    endcase
  end

  typedef struct {
    int v;
    bit s;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // Scoreboard consumer: compare every handshake on the observed instance
  always @(negedge clk) begin
    if (arst_n === 1'b1 && m_valid === 1'b1 && ready_in === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", sb.size(), 1);
      end else begin
        mon_e = sb.pop_front();
        $display("pop: data_out=%0d sat_out=%0b (expected %0d/%0b)", m_data, m_sat, mon_e.v, mon_e.s);
        chk("out_data", $signed(m_data), mon_e.v);
        chk("out_sat", {31'd0, m_sat}, {31'd0, mon_e.s});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int val);
    valid_in = 1'b1;
    data_in  = IW'(val);
    tick();
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    arst_n      = 1'b0;
    valid_in    = 1'b0;
    clr_overrun = 1'b0;
    tick();
    tick();
    sb.delete();
    arst_n = 1'b1;
  endtask

  initial begin
    int rin[5];
    int rexp[5];

    // ---------------- Reset state ----------------
    sel = 0;
    do_reset();
    chk("rst_valid", m_valid, 0);
    chk("rst_data", $signed(m_data), 0);
    chk("rst_sat", m_sat, 0);
    chk("rst_ovr", m_ovr, 0);

    // ---------------- Decimation by 4, latency 2 ----------------
    ready_in = 1'b1;
    sb.push_back('{1, 1'b0});
    sb.push_back('{5, 1'b0});
    for (int k = 0; k < 5; k++) begin
      drive(256 * (k + 1));
      chk("dec_valid_timing", m_valid, (k == 1) ? 1 : 0);
    end
    idle(1);
    chk("dec_second_valid", m_valid, 1);
    chk("dec_second_data", $signed(m_data), 5);
    idle(1);
    chk("dec_empty_valid", m_valid, 0);
    chk("dec_hold_data", $signed(m_data), 5);
    idle(2);
    chk("dec_sb_empty", sb.size(), 0);

    // ---------------- Rounding, DECIM=1 SHIFT=8 ----------------
    sel = 1;
    do_reset();
    ready_in = 1'b1;
    rin  = '{128, 127, -128, -129, 384};
    rexp = '{1, 0, 0, -1, 2};
    for (int k = 0; k < 5; k++) begin
      sb.push_back('{rexp[k], 1'b0});
      drive(rin[k]);
    end
    idle(4);
    chk("rnd_sb_empty", sb.size(), 0);

    // ---------------- Saturation, SHIFT=0 ----------------
    sel = 2;
    do_reset();
    ready_in = 1'b1;
    sb.push_back('{32767, 1'b1});
    drive(40000);
    sb.push_back('{-32768, 1'b1});
    drive(-40000);
    sb.push_back('{1000, 1'b0});
    drive(1000);
    idle(4);
    chk("sat_sb_empty", sb.size(), 0);
`ifdef FIR_DECIM_REQUANT_SAT_CNT_EN
    chk("sat_cnt", {16'd0, c_cnt}, 2);
`endif

    // ---------------- Backpressure and overrun ----------------
    sel = 1;
    do_reset();
    ready_in = 1'b0;
    sb.push_back('{10, 1'b0});
    sb.push_back('{20, 1'b0});
    drive(10 * 256);
    drive(20 * 256);
    drive(30 * 256);
    valid_in = 1'b0;
    chk("bp_ovr_before_drop", m_ovr, 0);
    tick();
    chk("bp_ovr_after_drop", m_ovr, 1);
    chk("bp_full_valid", m_valid, 1);
    chk("bp_head_data", $signed(m_data), 10);
    ready_in = 1'b1;
    idle(3);
    chk("bp_sb_empty", sb.size(), 0);
    chk("bp_drained_valid", m_valid, 0);
    chk("bp_ovr_sticky", m_ovr, 1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("bp_ovr_cleared", m_ovr, 0);

    // Drop and clear in the same cycle: the drop wins
    ready_in = 1'b0;
    sb.push_back('{40, 1'b0});
    sb.push_back('{50, 1'b0});
    drive(40 * 256);
    drive(50 * 256);
    drive(60 * 256);
    valid_in    = 1'b0;
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("bp_drop_beats_clr", m_ovr, 1);
    ready_in = 1'b1;
    idle(3);
    chk("bp2_sb_empty", sb.size(), 0);

    // ---------------- Full FIFO with simultaneous push/pop ----------------
    do_reset();
    ready_in = 1'b0;
    for (int k = 1; k <= 5; k++) sb.push_back('{k, 1'b0});
    drive(256);
    drive(512);
    drive(768);
    ready_in = 1'b1;
    drive(1024);
    drive(1280);
    idle(4);
    chk("conc_no_overrun", m_ovr, 0);
    chk("conc_sb_empty", sb.size(), 0);

    // ---------------- Reset mid-stream ----------------
    sel = 0;
    do_reset();
    ready_in = 1'b0;
    for (int k = 0; k < 9; k++) drive(256 * (k + 1));
    valid_in = 1'b0;
    chk("mid_full_valid", m_valid, 1);
    arst_n = 1'b0;
    tick();
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_data", $signed(m_data), 0);
    sb.delete();
    arst_n   = 1'b1;
    ready_in = 1'b1;
    sb.push_back('{7, 1'b0});
    sb.push_back('{9, 1'b0});
    drive(7 * 256);
    chk("mid_post_lat0", m_valid, 0);
    drive(256);
    chk("mid_post_valid", m_valid, 1);
    chk("mid_post_data", $signed(m_data), 7);
    drive(256);
    drive(256);
    drive(9 * 256);
    idle(4);
    chk("mid_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_decim_requant.md
Name: fir_decim_requant

Overview:
- Downstream stage of the symmetric odd FIR; consumes its full-precision `data_out`/`valid_out` stream.
- Keeps every DECIM-th valid sample, then rounds, shifts and saturates it to OUT_WIDTH.
- Buffers results in a 2-entry output FIFO with a valid/ready handshake toward the next consumer.
- The FIR has no backpressure, so overflow drops samples and raises a sticky flag.

Parameters:
- IN_WIDTH, 25: width of signed input; matches FIR output width for 16-bit data, 5-bit coeffs, 5 taps.
- OUT_WIDTH, 16: width of signed output.
- SHIFT, 8: arithmetic right shift applied after rounding; 0 ≤ SHIFT < IN_WIDTH.
- DECIM, 4: decimation factor; ≥ 1; DECIM = 1 keeps every sample.
- PHASE, 0: index of the kept sample within each DECIM group; 0 ≤ PHASE < DECIM.

Ports:
- clk, input, 1: clock; all logic on rising edge.
- arst_n, input, 1: synchronous active-low reset, sampled on rising clk.
- data_in, input, IN_WIDTH: signed sample from the FIR.
- valid_in, input, 1: data_in qualifier; single-cycle strobes, no ready returned upstream.
- data_out, output, OUT_WIDTH: signed requantised sample at the FIFO head.
- valid_out, output, 1: FIFO non-empty.
- ready_in, input, 1: downstream accepts data_out when valid_out && ready_in.
- sat_out, output, 1: saturation indicator travelling with data_out; high if the head sample was clipped.
- overrun, output, 1: sticky; set when a kept sample is dropped because the FIFO is full.
- clr_overrun, input, 1: clears overrun.

Behaviour:
- Reset (arst_n low at a clk edge), all of the following:
  - phase counter = 0, stage-1 valid = 0, FIFO empty.
  - valid_out = 0, data_out = 0, sat_out = 0, overrun = 0.
  - Reset mid-operation discards all in-flight samples.
- Phase counter:
  - Advances only on valid_in; wraps DECIM-1 → 0.
  - A sample is kept when valid_in is high and the counter equals PHASE.
  - Samples with valid_in low are ignored and do not advance the counter.
- Stage 1, registered, 1 cycle:
  - r = data_in + (SHIFT > 0 ? 2^(SHIFT-1) : 0), computed at IN_WIDTH+1 bits so the add cannot wrap. This is round-half-up.
  - q = r >>> SHIFT (arithmetic).
  - If q > 2^(OUT_WIDTH-1)-1: output max, sat = 1.
  - If q < -2^(OUT_WIDTH-1): output min, sat = 1.
  - Otherwise: output q, sat = 0.
  - Stage-1 register holds {value, sat} and a valid bit.
- Stage 2, FIFO (2 entries of {value, sat}):
  - Write when stage-1 valid and (count < 2, or a pop occurs in the same cycle).
  - Pop when valid_out && ready_in.
  - Head is registered and presented directly on data_out/sat_out.
  - Simultaneous push and pop at count 2: both occur, count stays 2, order is preserved.
  - Push when count = 2 with no pop: sample dropped, overrun set next cycle.
  - Empty FIFO: data_out/sat_out hold their last value; valid_out = 0.
- Latency:
  - Kept sample on valid_in at cycle n appears on data_out with valid_out = 1 at cycle n+2, when the FIFO is empty.
  - Throughput: one output per clock when ready_in is held high.
- overrun:
  - clr_overrun clears overrun.
  - A drop in the same cycle as clr_overrun wins: overrun = 1.
- Samples are never reordered or duplicated.

Optional Feature:
- Macro: FIR_DECIM_REQUANT_SAT_CNT_EN.
- Defined:
  - Adds output port sat_cnt [15:0].
  - Counts stage-1 samples with sat = 1, including later-dropped ones.
  - Saturates at 16'hFFFF; does not wrap.
  - Reset to 0; cleared by clr_overrun.
- Undefined: port absent, no counter logic.

Test Plan:
- Reset, then DECIM=4, PHASE=0, SHIFT=8, ready_in=1; valid_in every cycle with data_in = 256, 512, 768, 1024, 1280 → outputs 1 then 5; each valid_out appears 2 cycles after its kept input.
- Rounding with DECIM=1, SHIFT=8: data_in = 128 → 1; 127 → 0; -128 → 0; -129 → -1; 384 → 2.
- Saturation with SHIFT=0, OUT_WIDTH=16: data_in = 40000 → 32767, sat_out=1; -40000 → -32768, sat_out=1; 1000 → 1000, sat_out=0. With macro defined, sat_cnt = 2.
- Backpressure with DECIM=1: ready_in=0, push 3 samples (10, 20, 30) → FIFO holds 10, 20; 30 dropped; overrun=1. Raise ready_in → 10 then 20; clr_overrun → overrun=0.
- Full-FIFO concurrency: FIFO full, ready_in=1, new kept sample in the same cycle → no drop, overrun stays 0, output order intact.
- Reset mid-stream: assert arst_n=0 with FIFO holding 2 entries and stage 1 valid → next cycle valid_out=0, data_out=0; first post-reset kept sample uses phase 0.
